// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: issues data-memory requests, stalls upstream while a
// request is outstanding, and registers the MEM/WB outputs including error reporting.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [31:0] alu_res,
    input  logic [31:0] rt_data,
    input  logic [4:0]  reg_dest,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_res,
    output logic [4:0]  wb_reg_dest,
    output logic        mem_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Fields of the in-flight memory instruction, retired in DONE.
    logic        lat_mem_to_reg;
    logic        lat_reg_write;
    logic        lat_timeout;
    logic [31:0] lat_alu_res;
    logic [31:0] lat_data;
    logic [4:0]  lat_reg_dest;

    logic op;
    logic aligned;

    assign op      = mem_read | mem_write;
    assign aligned = (alu_res[1:0] == 2'b00);

    // Combinational so the upstream stages freeze in the same cycle the access is seen.
    assign stall = ((state == IDLE) && op && aligned) || (state == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            wb_mem_to_reg  <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_read_data   <= '0;
            wb_alu_res     <= '0;
            wb_reg_dest    <= '0;
            mem_err        <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_timeout    <= 1'b0;
            lat_alu_res    <= '0;
            lat_data       <= '0;
            lat_reg_dest   <= '0;
        end else begin
            // NOTE: defaults first; a later non-blocking assignment in this block overrides them.
            mem_err <= 1'b0;
            if (stall) begin
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!op) begin
                        wb_mem_to_reg <= mem_to_reg;
                        wb_reg_write  <= reg_write;
                        wb_read_data  <= '0;
                        wb_alu_res    <= alu_res;
                        wb_reg_dest   <= reg_dest;
                    end else if (!aligned) begin
                        wb_mem_to_reg <= 1'b0;
                        wb_reg_write  <= 1'b0;
                        wb_read_data  <= '0;
                        wb_alu_res    <= alu_res;
                        wb_reg_dest   <= reg_dest;
                        mem_err       <= 1'b1;
                    end else begin
                        state          <= ACCESS;
                        cnt            <= '0;
                        dmem_req       <= 1'b1;
                        dmem_we        <= mem_write;
                        dmem_addr      <= alu_res;
                        dmem_wdata     <= rt_data;
                        lat_mem_to_reg <= mem_to_reg;
                        lat_reg_write  <= reg_write;
                        lat_alu_res    <= alu_res;
                        lat_reg_dest   <= reg_dest;
                        lat_timeout    <= 1'b0;
                    end
                end

                ACCESS: begin
                    if (dmem_ack) begin
                        lat_data    <= dmem_we ? 32'd0 : dmem_rdata;
                        lat_timeout <= 1'b0;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            lat_data    <= '0;
                            lat_timeout <= 1'b1;
                            dmem_req    <= 1'b0;
                            dmem_we     <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end

                DONE: begin
                    wb_mem_to_reg <= lat_mem_to_reg;
                    wb_reg_write  <= lat_reg_write & ~lat_timeout;
                    wb_read_data  <= lat_timeout ? 32'd0 : lat_data;
                    wb_alu_res    <= lat_alu_res;
                    wb_reg_dest   <= lat_reg_dest;
                    mem_err       <= lat_timeout;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        clk, rst;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic [31:0] alu_res, rt_data;
    logic [4:0]  reg_dest;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, stall;
    logic        wb_mem_to_reg, wb_reg_write;
    logic [31:0] wb_read_data, wb_alu_res;
    logic [4:0]  wb_reg_dest;
    logic        mem_err;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_res(alu_res), .rt_data(rt_data), .reg_dest(reg_dest),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_read_data(wb_read_data),
        .wb_alu_res(wb_alu_res), .wb_reg_dest(wb_reg_dest), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_stall, n_req, n_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: an outstanding request, a pending retirement, and its payload.
    bit          m_busy, m_done, m_tmo, m_is_write;
    int          m_cycles;
    logic        m_m2r, m_rw;
    logic [31:0] m_alu, m_data;
    logic [4:0]  m_dst;
    logic        e_req, e_we, e_m2r, e_rw, e_err;
    logic [31:0] e_addr, e_wdata, e_rd, e_alu;
    logic [4:0]  e_dst;
    logic        e_stall;

    assign e_stall = m_busy || (!m_done && (mem_read || mem_write) && alu_res[1:0] == 2'b00);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_tmo = 0; m_is_write = 0; m_cycles = 0;
            m_m2r = 0; m_rw = 0; m_alu = 0; m_data = 0; m_dst = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_m2r = 0; e_rw = 0; e_rd = 0; e_alu = 0; e_dst = 0; e_err = 0;
        end else begin
            e_err = 0;
            if (m_done) begin
                e_m2r = m_m2r; e_rw = m_rw && !m_tmo; e_rd = m_tmo ? 0 : m_data;
                e_alu = m_alu; e_dst = m_dst; e_err = m_tmo;
                m_done = 0;
            end else if (m_busy) begin
                e_rw = 0; e_m2r = 0;
                m_cycles++;
                if (dmem_ack) begin
                    m_data = m_is_write ? 0 : dmem_rdata;
                    m_tmo = 0; m_busy = 0; m_done = 1; e_req = 0; e_we = 0;
                end else if (m_cycles == TIMEOUT) begin
                    m_tmo = 1; m_busy = 0; m_done = 1; e_req = 0; e_we = 0;
                end
            end else if (mem_read || mem_write) begin
                if (alu_res[1:0] != 2'b00) begin
                    e_m2r = 0; e_rw = 0; e_rd = 0; e_alu = alu_res; e_dst = reg_dest; e_err = 1;
                end else begin
                    e_rw = 0; e_m2r = 0;
                    m_busy = 1; m_cycles = 0; m_is_write = mem_write;
                    e_req = 1; e_we = mem_write; e_addr = alu_res; e_wdata = rt_data;
                    m_m2r = mem_to_reg; m_rw = reg_write; m_alu = alu_res; m_dst = reg_dest;
                end
            end else begin
                e_m2r = mem_to_reg; e_rw = reg_write; e_rd = 0; e_alu = alu_res; e_dst = reg_dest;
            end
        end
    end

    always @(negedge clk) begin
        check("stall", stall, e_stall);
        check("dmem_req", dmem_req, e_req);
        check("dmem_we", dmem_we, e_we);
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_wdata", dmem_wdata, e_wdata);
        check("wb_mem_to_reg", wb_mem_to_reg, e_m2r);
        check("wb_reg_write", wb_reg_write, e_rw);
        check("wb_read_data", wb_read_data, e_rd);
        check("wb_alu_res", wb_alu_res, e_alu);
        check("wb_reg_dest", wb_reg_dest, e_dst);
        check("mem_err", mem_err, e_err);
        if (stall) n_stall++;
        if (dmem_req) n_req++;
        if (dmem_we) n_we++;
    end

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dst);
        mem_read = rd; mem_write = wr; mem_to_reg = m2r; reg_write = rw;
        alu_res = alu; rt_data = rt; reg_dest = dst;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_stall = 0; n_req = 0; n_we = 0;
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        nop();
        clear_counts();
        repeat (2) settle();
        check("rst dmem_req", dmem_req, 0);
        check("rst stall", stall, 0);
        check("rst wb_reg_write", wb_reg_write, 0);
        check("rst mem_err", mem_err, 0);
        @(posedge clk); #2; rst = 1'b0;

        // ALU pass-through
        clear_counts();
        drive(0, 0, 0, 1, 32'h0000_0040, 32'h0, 5'd5);
        step(); nop();
        settle();
        check("alu wb_alu_res", wb_alu_res, 32'h40);
        check("alu wb_reg_write", wb_reg_write, 1);
        check("alu wb_reg_dest", wb_reg_dest, 5);
        check("alu stall cycles", n_stall, 0);

        // Load, ack in the third ACCESS cycle
        step(); clear_counts();
        drive(1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd7);
        step(); step();
        step(); dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        step(); dmem_ack = 0; dmem_rdata = 32'h0;
        step(); nop();
        settle();
        check("load stall cycles", n_stall, 4);
        check("load req cycles", n_req, 3);
        check("load wb_read_data", wb_read_data, 32'hDEAD_BEEF);
        check("load wb_mem_to_reg", wb_mem_to_reg, 1);
        check("load wb_reg_write", wb_reg_write, 1);

        // Store, ack in the first ACCESS cycle
        step(); clear_counts();
        drive(0, 1, 0, 0, 32'h0000_0200, 32'h1234_5678, 5'd0);
        step(); dmem_ack = 1;
        settle();
        check("store dmem_we", dmem_we, 1);
        check("store dmem_wdata", dmem_wdata, 32'h1234_5678);
        check("store dmem_addr", dmem_addr, 32'h200);
        step(); dmem_ack = 0;
        step(); nop();
        settle();
        check("store stall cycles", n_stall, 2);
        check("store we cycles", n_we, 1);
        check("store wb_reg_write", wb_reg_write, 0);

        // Misaligned load
        step(); clear_counts();
        drive(1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd3);
        step(); nop();
        settle();
        check("misal mem_err", mem_err, 1);
        check("misal wb_reg_write", wb_reg_write, 0);
        check("misal wb_read_data", wb_read_data, 0);
        check("misal req cycles", n_req, 0);
        check("misal stall cycles", n_stall, 0);
        step(); settle();
        check("misal mem_err pulse end", mem_err, 0);

        // Read and write both set: handled as a write, no read data returned
        step(); clear_counts();
        drive(1, 1, 0, 0, 32'h0000_0500, 32'hA5A5_A5A5, 5'd4);
        step(); dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
        settle();
        check("rw dmem_we", dmem_we, 1);
        step(); dmem_ack = 0; dmem_rdata = 32'h0;
        step(); nop();
        settle();
        check("rw wb_read_data", wb_read_data, 0);

        // Timeout with a late ack during DONE
        step(); clear_counts();
        drive(1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd8);
        repeat (4) step();
        step(); dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        step(); nop();
        settle();
        check("tmo mem_err", mem_err, 1);
        check("tmo wb_reg_write", wb_reg_write, 0);
        check("tmo wb_read_data", wb_read_data, 0);
        check("tmo req cycles", n_req, 4);
        check("tmo stall cycles", n_stall, 5);
        step(); dmem_ack = 0; dmem_rdata = 32'h0;
        settle();
        check("tmo mem_err pulse end", mem_err, 0);
        check("tmo late ack req", dmem_req, 0);

        // Reset in the second ACCESS cycle
        step();
        drive(1, 0, 1, 1, 32'h0000_0400, 32'h0, 5'd9);
        step(); step();
        #1; rst = 1'b1; nop();
        #1;
        check("rst mid dmem_req", dmem_req, 0);
        check("rst mid stall", stall, 0);
        step(); rst = 1'b0; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
        step(); dmem_ack = 0; dmem_rdata = 32'h0; clear_counts();
        drive(0, 0, 0, 1, 32'h0000_0088, 32'h0, 5'd9);
        step(); nop();
        settle();
        check("post-rst wb_alu_res", wb_alu_res, 32'h88);
        check("post-rst wb_reg_write", wb_reg_write, 1);
        check("post-rst wb_reg_dest", wb_reg_dest, 9);
        check("post-rst req cycles", n_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
